// File: rtl/fdiv_if.sv
// Operand/result bundle for the single-precision divider.
// The master issues operands and start; the slave returns the quotient and status.
interface fdiv_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic [31:0] c;
    logic        ready;
    logic        busy;

    modport master (output a, b, en, input c, ready, busy);
    modport slave  (input a, b, en, output c, ready, busy);
endinterface

// File: rtl/fdiv.sv
// Iterative restoring single-precision divider, fixed latency per operation.
// Define FDIV_RADIX4_EN to retire two quotient bits per DIV cycle (same results, shorter latency).
module fdiv (
    input logic   clk,
    input logic   rst,
    fdiv_if.slave bus
);

`ifdef FDIV_RADIX4_EN
    localparam int unsigned BitsPerCycle = 2;
`else
    localparam int unsigned BitsPerCycle = 1;
`endif
    localparam int unsigned LastCount = 26 / BitsPerCycle - 1;

    typedef enum logic [1:0] {StIdle, StDiv, StPack} state_e;

    state_e      state;
    logic        sign;
    logic [9:0]  exp_q;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic        za;
    logic        zb;
    logic [25:0] q;
    logic [4:0]  cnt;

    // One restoring step: {quotient bit, next remainder}. rem < 2*dvs keeps bit 24 free.
    function automatic logic [25:0] div_step(input logic [24:0] r, input logic [23:0] d);
        logic [24:0] diff;
        diff = r - {1'b0, d};
        if (r >= {1'b0, d}) begin
            return {1'b1, diff[23:0], 1'b0};
        end else begin
            return {1'b0, r[23:0], 1'b0};
        end
    endfunction

    logic [25:0] step1;
`ifdef FDIV_RADIX4_EN
    logic [25:0] step2;
`endif

    always_comb begin
        step1 = div_step(rem, dvs);
`ifdef FDIV_RADIX4_EN
        step2 = div_step(step1[24:0], dvs);
`endif
    end

    logic [22:0] m_raw;
    logic        guard;
    logic [9:0]  exp_n;
    logic [23:0] m_inc;
    logic [9:0]  exp_fin;
    logic [31:0] pack_c;

    always_comb begin
        if (q[25]) begin
            m_raw = q[24:2];
            guard = q[1];
            exp_n = exp_q;
        end else begin
            m_raw = q[23:1];
            guard = q[0];
            exp_n = exp_q - 10'd1;
        end
        // A carry out of the mantissa already leaves m_inc[22:0] at zero.
        m_inc   = {1'b0, m_raw} + {23'b0, guard};
        exp_fin = exp_n + {9'b0, m_inc[23]};

        if (za) begin
            pack_c = {sign, 31'b0};
        end else if (zb) begin
            pack_c = {sign, 8'hFF, 23'b0};
        end else if (exp_fin[9] || (exp_fin == 10'd0)) begin
            pack_c = {sign, 31'b0};
        end else if (exp_fin >= 10'd255) begin
            pack_c = {sign, 8'hFF, 23'b0};
        end else begin
            pack_c = {sign, exp_fin[7:0], m_inc[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            bus.c     <= 32'b0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
            sign      <= 1'b0;
            exp_q     <= 10'b0;
            rem       <= 25'b0;
            dvs       <= 24'b0;
            za        <= 1'b0;
            zb        <= 1'b0;
            q         <= 26'b0;
            cnt       <= 5'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    bus.ready <= 1'b0;
                    if (bus.en) begin
                        sign     <= bus.a[31] ^ bus.b[31];
                        exp_q    <= {2'b0, bus.a[30:23]} - {2'b0, bus.b[30:23]} + 10'd127;
                        rem      <= {2'b01, bus.a[22:0]};
                        dvs      <= {1'b1, bus.b[22:0]};
                        za       <= (bus.a[30:23] == 8'd0);
                        zb       <= (bus.b[30:23] == 8'd0);
                        q        <= 26'b0;
                        cnt      <= 5'b0;
                        bus.busy <= 1'b1;
                        state    <= StDiv;
                    end
                end
                StDiv: begin
`ifdef FDIV_RADIX4_EN
                    rem <= step2[24:0];
                    q   <= {q[23:0], step1[25], step2[25]};
`else
                    rem <= step1[24:0];
                    q   <= {q[24:0], step1[25]};
`endif
                    if (cnt == 5'(LastCount)) begin
                        state <= StPack;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                StPack: begin
                    bus.c     <= pack_c;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
